uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Memory-mapped responder on the CPU data bus: buffered 8N1 UART transmitter with a programmable baud divider.
- Selected by its own decoder chip-select. Uses the same CS_N/RD_N/WR_N/Addr/DataIn/DataOut/Intr strobe style as the other peripherals.
- Software pushes bytes into a FIFO. A shift FSM drains the FIFO onto TxD.
- Intr flags "FIFO drained and line idle".

Parameters:
- FIFO_DEPTH, 8: entries, power of two, range 2..16.
- DEFAULT_DIV, 16'd234: baud divider after reset, in clk cycles per bit.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- CS_N  in  1  chip select, active low.
- RD_N  in  1  read strobe, active low.
- WR_N  in  1  write strobe, active low.
- Addr  in  12  byte address; only Addr[3:2] is decoded.
- DataIn  in  32  write data.
- DataOut  out  32  read data, combinational.
- TxD  out  1  serial output, idle high.
- Intr  out  1  interrupt, active low.

Behaviour:
- Register map, selected by Addr[3:2]:
  - 0 TXDATA: write pushes DataIn[7:0]; reads 0.
  - 1 STATUS: read-only. [0] full, [1] empty, [2] busy (FSM not IDLE), [7:3] count, [8] ovf sticky, others 0.
  - 2 CTRL: [0] tx_en, [1] irq_en. Writing 1 to [2] clears ovf; [2] reads 0.
  - 3 BAUDDIV: [15:0]. Writes below 2 are stored as 2.
- Write event: rising edge with CS_N=0 and WR_N=0. One write event per asserted edge; the bus holds a write for exactly one clk cycle.
- DataOut: combinational from Addr/registers when CS_N=0 and RD_N=0, else 32'h0. Reads have no side effects.
- Reset (reset=0 at an edge) sets:
  - FIFO empty, count 0, ovf 0, tx_en 0, irq_en 0, BAUDDIV=DEFAULT_DIV.
  - FSM IDLE, TxD=1, Intr=1.
  - Reset mid-frame aborts the frame. TxD is 1 from the following edge; the FIFO contents are lost.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - Push when full: byte dropped, ovf set.
  - Pop happens only on the IDLE->START transition.
  - Simultaneous push and pop on the same edge while full: push accepted, no ovf, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if tx_en=1 and FIFO not empty, pop head into shift register; go to START; bit counter=0; baud counter=BAUDDIV-1.
  - Each state holds one bit for exactly BAUDDIV cycles. The baud counter counts down and the bit boundary is at 0.
  - START drives TxD=0.
  - DATA drives shift[0], LSB first, and shifts right at each bit boundary. After 8 bits go to STOP.
  - STOP drives TxD=1. At its boundary go to IDLE, which can immediately start the next byte (back-to-back frames, no idle gap).
  - Frame length is 10*BAUDDIV cycles.
  - tx_en cleared mid-frame: current frame completes; no new pop.
  - BAUDDIV written mid-frame: takes effect at the next baud counter reload.
- TxD is registered. The first START cycle begins the edge after the pop.
- Intr = ~(irq_en & empty & FSM==IDLE), registered (one-cycle latency from the condition).
- count = number of entries in FIFO (0..FIFO_DEPTH).

Test Plan:
- Reset, then read STATUS -> DataOut=32'h0000_0002 (empty). Read BAUDDIV -> 234. TxD=1, Intr=1.
- BAUDDIV=4, CTRL=1, write TXDATA=8'hA5 -> TxD sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, 40 cycles total. Then busy=0 and empty=1.
- tx_en=0, push 9 bytes 0x00..0x08 with FIFO_DEPTH=8 -> STATUS=32'h0000_0141 (ovf, count 8, full). Write CTRL=32'h5 -> ovf clears, transmission starts. Bytes 0x00..0x07 are sent back-to-back with no idle cycles between STOP and the next START.
- BAUDDIV write of 1 -> reads back 2. One byte sent -> 20-cycle frame.
- CTRL=3, push one byte -> Intr=1 during the frame. Intr=0 one cycle after return to IDLE with FIFO empty. Write CTRL=1 -> Intr=1.
- Assert reset during DATA bit 3 of byte 0x3C -> TxD=1 next edge, STATUS=2, FSM IDLE, no further frame bits.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CPU data-bus strobes, address and data for the UART TX peripheral
interface uart_tx_fifo_if;
    logic        CS_N;
    logic        RD_N;
    logic        WR_N;
    logic [11:0] Addr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    modport master(output CS_N, RD_N, WR_N, Addr, DataIn, input DataOut);
    modport slave(input CS_N, RD_N, WR_N, Addr, DataIn, output DataOut);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: bus-mapped 8N1 UART transmitter fed by a byte FIFO, programmable baud divider
module uart_tx_fifo #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd234
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus,
    output logic           TxD,
    output logic           Intr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [4:0]    count;
    logic          ovf, tx_en, irq_en;
    logic [15:0]   div, baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [1:0]    sel;
    logic          we, full, empty, busy, boundary, pop, push_req, push;
    logic          unused_bits;
    assign unused_bits = ^{bus.Addr[11:4], bus.Addr[1:0], bus.DataIn[31:16]};
    assign sel      = bus.Addr[3:2];
    assign we       = !bus.CS_N && !bus.WR_N;
    assign full     = count == 5'(FIFO_DEPTH);
    assign empty    = count == 5'd0;
    assign busy     = state != IDLE;
    assign boundary = baud_cnt == 16'd0;
    // A STOP boundary passes straight through IDLE so back-to-back frames have no gap
    assign pop      = tx_en && !empty && (state == IDLE || (state == STOP && boundary));
    assign push_req = we && sel == 2'd0;
    assign push     = push_req && (!full || pop);
    assign bus.DataOut = (!bus.CS_N && !bus.RD_N) ?
        (sel == 2'd1 ? {23'd0, ovf, count, busy, empty, full} :
         sel == 2'd2 ? {30'd0, irq_en, tx_en} :
         sel == 2'd3 ? {16'd0, div} : 32'd0) : 32'd0;
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= 5'd0;
            ovf      <= 1'b0;
            tx_en    <= 1'b0;
            irq_en   <= 1'b0;
            div      <= DEFAULT_DIV;
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            TxD      <= 1'b1;
            Intr     <= 1'b1;
        end else begin
            if (push) begin
                mem[wptr] <= bus.DataIn[7:0];
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count + {4'd0, push} - {4'd0, pop};
            if (push_req && !push) ovf <= 1'b1;
            else if (we && sel == 2'd2 && bus.DataIn[2]) ovf <= 1'b0;
            if (we && sel == 2'd2) begin
                tx_en  <= bus.DataIn[0];
                irq_en <= bus.DataIn[1];
            end
            if (we && sel == 2'd3) div <= bus.DataIn[15:0] < 16'd2 ? 16'd2 : bus.DataIn[15:0];
            Intr <= ~(irq_en & empty & ~busy);
            if (pop) begin
                shift    <= mem[rptr];
                state    <= START;
                bit_cnt  <= 3'd0;
                baud_cnt <= div - 16'd1;
                TxD      <= 1'b0;
            end else if (busy) begin
                if (!boundary) begin
                    baud_cnt <= baud_cnt - 16'd1;
                end else begin
                    baud_cnt <= div - 16'd1;
                    if (state == START) begin
                        state <= DATA;
                        TxD   <= shift[0];
                    end else if (state == DATA) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                        state   <= bit_cnt == 3'd7 ? STOP : DATA;
                        TxD     <= bit_cnt == 3'd7 ? 1'b1 : shift[1];
                    end else begin
                        state <= IDLE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bus stimulus checked against a queue-based model of the serial line
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic TxD, Intr;
    int vectors = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    logic [31:0] rd;
    uart_tx_fifo_if bus();
    uart_tx_fifo #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd234)) dut (
        .clk(clk), .reset(reset), .bus(bus), .TxD(TxD), .Intr(Intr)
    );
    always #5 clk = ~clk;

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.Addr   = (12'($urandom) & 12'hFF3) | {8'd0, a};
        bus.DataIn = d;
        bus.CS_N   = 1'b0;
        bus.WR_N   = 1'b0;
        @(negedge clk);
        bus.CS_N   = 1'b1;
        bus.WR_N   = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus.Addr = (12'($urandom) & 12'hFF3) | {8'd0, a};
        bus.CS_N = 1'b0;
        bus.RD_N = 1'b0;
        #1 d = bus.DataOut;
        bus.CS_N = 1'b1;
        bus.RD_N = 1'b1;
    endtask

    // Every byte in exp_q must appear as a contiguous 10-bit frame, each bit dv cycles long
    task automatic check_stream(input int dv, input bit chk_intr, input string tag);
        int w = 0;
        logic [9:0] fr;
        while (TxD !== 1'b0 && w < 64) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (TxD !== 1'b0) begin
            fails++;
            $display("FAIL %s start: TxD=%b, required 0 within 64 cycles", tag, TxD);
            exp_q.delete();
            return;
        end
        foreach (exp_q[i]) begin
            fr = {1'b1, exp_q[i], 1'b0};
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < dv; c++) begin
                    vectors++;
                    if (TxD !== fr[k] || (chk_intr && Intr !== 1'b1)) begin
                        fails++;
                        if (fails < 20)
                            $display("FAIL %s byte %0d bit %0d cyc %0d: TxD=%b Intr=%b, required TxD=%b%s",
                                     tag, i, k, c, TxD, Intr, fr[k], chk_intr ? " Intr=1" : "");
                    end
                    @(negedge clk);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.CS_N = 1'b1; bus.RD_N = 1'b1; bus.WR_N = 1'b1;
        bus.Addr = 12'd0; bus.DataIn = 32'd0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus_read(4'h4, rd);
        vectors++; if (rd !== 32'h2) begin fails++; $display("FAIL reset status: got %h, required 00000002", rd); end
        bus_read(4'hC, rd);
        vectors++; if (rd !== 32'd234) begin fails++; $display("FAIL reset bauddiv: got %0d, required 234", rd); end
        bus_read(4'h8, rd);
        vectors++; if (rd !== 32'h0) begin fails++; $display("FAIL reset ctrl: got %h, required 0", rd); end
        vectors++; if (TxD !== 1'b1 || Intr !== 1'b1) begin fails++; $display("FAIL reset lines: TxD=%b Intr=%b, required 1 1", TxD, Intr); end
        bus.Addr = 12'h4; bus.RD_N = 1'b0;
        #1 vectors++;
        if (bus.DataOut !== 32'h0) begin fails++; $display("FAIL unselected read: got %h, required 0", bus.DataOut); end
        bus.RD_N = 1'b1;
    endtask

    task automatic test_basic();
        bus_write(4'hC, 32'd4);
        bus_write(4'h8, 32'd1);
        exp_q.push_back(8'hA5);
        bus_write(4'h0, 32'hA5);
        check_stream(4, 1'b0, "basic");
        bus_read(4'h4, rd);
        vectors++; if (rd !== 32'h2 || TxD !== 1'b1) begin fails++; $display("FAIL basic after: status=%h TxD=%b, required 00000002 1", rd, TxD); end
    endtask

    task automatic test_overflow();
        bus_write(4'h8, 32'd0);
        for (int i = 0; i < 9; i++) bus_write(4'h0, 32'(i));
        bus_read(4'h4, rd);
        vectors++; if (rd !== 32'h141) begin fails++; $display("FAIL ovf status: got %h, required 00000141", rd); end
        bus_write(4'h8, 32'h5);
        bus_write(4'h0, 32'h8);
        bus_read(4'h4, rd);
        vectors++; if (rd !== 32'h45) begin fails++; $display("FAIL push-on-pop status: got %h, required 00000045", rd); end
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(i));
        check_stream(4, 1'b0, "b2b");
    endtask

    task automatic test_random();
        int dv, n, cnt;
        bit ovf_m;
        logic [7:0] b;
        for (int it = 0; it < 3; it++) begin
            dv = int'($urandom_range(2, 6));
            bus_write(4'h8, 32'd0);
            bus_write(4'hC, 32'(dv));
            n = int'($urandom_range(1, 12));
            ovf_m = 1'b0;
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                if (exp_q.size() < 8) exp_q.push_back(b);
                else ovf_m = 1'b1;
                bus_write(4'h0, {24'($urandom), b});
            end
            cnt = exp_q.size();
            bus_read(4'h4, rd);
            vectors++;
            if (rd !== {23'd0, ovf_m, 5'(cnt), 1'b0, cnt == 0, cnt == 8}) begin
                fails++; $display("FAIL random status it %0d: got %h, required count %0d ovf %b", it, rd, cnt, ovf_m);
            end
            bus_write(4'h8, 32'h5);
            check_stream(dv, 1'b0, "random");
        end
    endtask

    task automatic test_baud_min();
        logic [7:0] b;
        bus_write(4'hC, 32'd1);
        bus_read(4'hC, rd);
        vectors++; if (rd !== 32'd2) begin fails++; $display("FAIL baud min: got %0d, required 2", rd); end
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(4'h0, {24'd0, b});
        check_stream(2, 1'b0, "div2");
        bus_read(4'h4, rd);
        vectors++; if (rd !== 32'h2 || TxD !== 1'b1) begin fails++; $display("FAIL div2 after: status=%h TxD=%b, required 00000002 1", rd, TxD); end
    endtask

    task automatic test_intr();
        logic [7:0] b;
        bus_write(4'h8, 32'h3);
        vectors++; if (Intr !== 1'b1) begin fails++; $display("FAIL intr latency: Intr=%b, required 1", Intr); end
        @(negedge clk);
        vectors++; if (Intr !== 1'b0) begin fails++; $display("FAIL intr idle: Intr=%b, required 0", Intr); end
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(4'h0, {24'd0, b});
        check_stream(2, 1'b1, "intr frame");
        vectors++; if (Intr !== 1'b1) begin fails++; $display("FAIL intr at return: Intr=%b, required 1", Intr); end
        @(negedge clk);
        vectors++; if (Intr !== 1'b0) begin fails++; $display("FAIL intr after return: Intr=%b, required 0", Intr); end
        bus_write(4'h8, 32'h1);
        @(negedge clk);
        vectors++; if (Intr !== 1'b1) begin fails++; $display("FAIL intr disable: Intr=%b, required 1", Intr); end
    endtask

    task automatic test_reset_mid();
        int w = 0;
        int low = 0;
        bus_write(4'hC, 32'd4);
        bus_write(4'h8, 32'd1);
        bus_write(4'h0, 32'h3C);
        bus_write(4'h0, 32'h55);
        while (TxD !== 1'b0 && w < 64) begin
            @(negedge clk);
            w++;
        end
        repeat (17) @(negedge clk);
        bus_read(4'h4, rd);
        vectors++; if (rd !== 32'h0C) begin fails++; $display("FAIL mid-frame status: got %h, required 0000000c", rd); end
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (TxD !== 1'b1) begin fails++; $display("FAIL reset abort TxD: got %b, required 1", TxD); end
        reset = 1'b1;
        bus_read(4'h4, rd);
        vectors++; if (rd !== 32'h2) begin fails++; $display("FAIL reset abort status: got %h, required 00000002", rd); end
        repeat (60) begin
            @(negedge clk);
            if (TxD !== 1'b1) low++;
        end
        vectors++; if (low != 0) begin fails++; $display("FAIL reset abort line: %0d low cycles, required 0", low); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_random();
        test_baud_min();
        test_intr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
